// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 display memory: screen geometry,
// framebuffer controller states and a pixel index helper.
package chip8_pkg;

  localparam int SCREEN_W = 64;
  localparam int SCREEN_H = 32;

  typedef enum logic [1:0] {
    FB_IDLE,
    FB_CLEAR,
    FB_SCAN
  } fb_state_t;

  // Row-major pixel index on the default screen geometry.
  function automatic int unsigned pix_index(input int unsigned x, input int unsigned y);
    return y * SCREEN_W + x;
  endfunction

endpackage

// File: rtl/chip8_fb_scanner.sv
// Row streamer for the framebuffer: current row number, valid/ready
// handshake and the end-of-frame pulse. With CHIP8_FB_DIRTY_EN defined it
// also keeps a per-row dirty vector and emits only dirty rows, lowest first.
module chip8_fb_scanner
  import chip8_pkg::*;
#(
  parameter int HEIGHT = SCREEN_H,
  parameter int RW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scan_i,
  input  logic          rowReady_i,
  input  logic          flip_i,
  input  logic [RW-1:0] flipRow_i,
  input  logic          clr_i,
  input  logic [RW-1:0] clrRow_i,
  output logic          rowValid_o,
  output logic [RW-1:0] rowIdx_o,
  output logic          frameDone_o
);

  logic done_q, done_d;
  logic accept;

  assign accept      = rowValid_o && rowReady_i;
  assign frameDone_o = done_q;

`ifdef CHIP8_FB_DIRTY_EN
  logic [HEIGHT-1:0] dirty_q, dirty_d;
  logic [HEIGHT-1:0] selMask;
  logic [RW-1:0]     sel;

  // Lowest-numbered dirty row is the one offered next.
  always_comb begin
    sel     = '0;
    selMask = '0;
    for (int r = HEIGHT - 1; r >= 0; r--) begin
      if (dirty_q[r]) sel = RW'(r);
    end
    selMask[sel] = 1'b1;
  end

  assign rowValid_o = scan_i && !done_q && (|dirty_q);
  assign rowIdx_o   = sel;

  // Dirty bookkeeping; a flip or clear in the accept cycle wins over the clear-on-accept.
  always_comb begin
    dirty_d = dirty_q;
    done_d  = 1'b0;
    if (accept) begin
      dirty_d[sel] = 1'b0;
      if ((dirty_q & ~selMask) == '0) done_d = 1'b1;
    end
    if (scan_i && !done_q && !(|dirty_q)) done_d = 1'b1;
    if (flip_i) dirty_d[flipRow_i] = 1'b1;
    if (clr_i)  dirty_d[clrRow_i]  = 1'b1;
  end

  // State registers; reset marks every row dirty.
  always_ff @(posedge clk) begin
    if (reset) begin
      dirty_q <= '1;
      done_q  <= 1'b0;
    end else begin
      dirty_q <= dirty_d;
      done_q  <= done_d;
    end
  end
`else
  logic [RW-1:0] scanRow_q, scanRow_d;
  logic          unused_dirty_inputs;

  assign unused_dirty_inputs = ^{flip_i, flipRow_i, clr_i, clrRow_i};
  assign rowValid_o = scan_i && !done_q;
  assign rowIdx_o   = scanRow_q;

  // Step through every row; wrap and raise the frame pulse after the last one.
  always_comb begin
    scanRow_d = scanRow_q;
    done_d    = 1'b0;
    if (accept) begin
      if (scanRow_q == RW'(HEIGHT - 1)) begin
        scanRow_d = '0;
        done_d    = 1'b1;
      end else begin
        scanRow_d = scanRow_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      scanRow_q <= '0;
      done_q    <= 1'b0;
    end else begin
      scanRow_q <= scanRow_d;
      done_q    <= done_d;
    end
  end
`endif

endmodule

// File: rtl/chip8_framebuffer.sv
// CHIP-8 monochrome display memory: XOR draw port for the core, row-per-cycle
// clear, and a row streamer towards the display driver.
// Optional build macro: CHIP8_FB_DIRTY_EN (emit only rows changed since last scan).
module chip8_framebuffer
  import chip8_pkg::*;
#(
  parameter int WIDTH  = SCREEN_W,
  parameter int HEIGHT = SCREEN_H,
  parameter int ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         gfxAddr,
  input  logic                      gfxFlip,
  input  logic                      gfxFlipEn,
  output logic                      gfxVal,
  input  logic                      clearReq,
  output logic                      busy,
  input  logic                      scanReq,
  output logic                      rowValid,
  input  logic                      rowReady,
  output logic [WIDTH-1:0]          rowData,
  output logic [$clog2(HEIGHT)-1:0] rowIdx,
  output logic                      frameDone
);

  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int IDX_W = XW + YW;

  fb_state_t      state_q, state_d;
  logic [YW-1:0]  clrRow_q, clrRow_d;
  logic           clrPend_q, clrPend_d;
  logic           scanPend_q, scanPend_d;

  logic [WIDTH-1:0] pix_q [HEIGHT];

  // The core does not clip: only the low index bits select a pixel, so
  // out-of-range coordinates wrap. ADDR_W is assumed wider than the index.
  logic [XW-1:0] flipX;
  logic [YW-1:0] flipY;
  logic          flipEn;
  logic          unused_addr_hi;

  assign flipX          = gfxAddr[XW-1:0];
  assign flipY          = gfxAddr[IDX_W-1:XW];
  assign unused_addr_hi = ^gfxAddr[ADDR_W-1:IDX_W];

  assign busy    = (state_q == FB_CLEAR);
  assign flipEn  = gfxFlipEn && gfxFlip && !busy;
  assign gfxVal  = pix_q[flipY][flipX];
  assign rowData = pix_q[rowIdx];

  chip8_fb_scanner #(
    .HEIGHT (HEIGHT),
    .RW     (YW)
  ) u_scanner (
    .clk         (clk),
    .reset       (reset),
    .scan_i      (state_q == FB_SCAN),
    .rowReady_i  (rowReady),
    .flip_i      (flipEn),
    .flipRow_i   (flipY),
    .clr_i       (busy),
    .clrRow_i    (clrRow_q),
    .rowValid_o  (rowValid),
    .rowIdx_o    (rowIdx),
    .frameDone_o (frameDone)
  );

  // Controller next state: clear has priority, requests arriving while busy are held one deep.
  always_comb begin
    state_d    = state_q;
    clrRow_d   = clrRow_q;
    clrPend_d  = clrPend_q;
    scanPend_d = scanPend_q;
    case (state_q)
      FB_IDLE: begin
        if (clearReq) begin
          state_d    = FB_CLEAR;
          clrRow_d   = '0;
          scanPend_d = scanPend_q || scanReq;
        end else if (scanReq || scanPend_q) begin
          state_d    = FB_SCAN;
          scanPend_d = 1'b0;
        end
      end
      FB_CLEAR: begin
        scanPend_d = scanPend_q || scanReq;
        clrRow_d   = clrRow_q + 1'b1;
        if (clrRow_q == YW'(HEIGHT - 1)) begin
          clrRow_d = '0;
          if (scanPend_d) begin
            state_d    = FB_SCAN;
            scanPend_d = 1'b0;
          end else begin
            state_d = FB_IDLE;
          end
        end
      end
      FB_SCAN: begin
        clrPend_d  = clrPend_q || clearReq;
        scanPend_d = scanPend_q || scanReq;
        if (frameDone) begin
          if (clrPend_d) begin
            state_d   = FB_CLEAR;
            clrRow_d  = '0;
            clrPend_d = 1'b0;
          end else begin
            state_d = FB_IDLE;
          end
        end
      end
      default: state_d = FB_IDLE;
    endcase
  end

  // Controller registers; reset restarts a full clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FB_CLEAR;
      clrRow_q   <= '0;
      clrPend_q  <= 1'b0;
      scanPend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clrRow_q   <= clrRow_d;
      clrPend_q  <= clrPend_d;
      scanPend_q <= scanPend_d;
    end
  end

  // Pixel array: clear zeroes one row per cycle, otherwise XOR the addressed pixel.
  always_ff @(posedge clk) begin
    for (int r = 0; r < HEIGHT; r++) begin
      if (busy && (clrRow_q == YW'(r))) begin
        pix_q[r] <= '0;
      end else if (flipEn && (flipY == YW'(r))) begin
        pix_q[r][flipX] <= ~pix_q[r][flipX];
      end
    end
  end

endmodule

// File: tb/tb_chip8_framebuffer.sv
// Self-checking bench for chip8_framebuffer, including the CHIP8_FB_DIRTY_EN build.
module tb_chip8_framebuffer;
  import chip8_pkg::*;

  localparam int W  = SCREEN_W;
  localparam int H  = SCREEN_H;
  localparam int AW = 16;

  logic          clk;
  logic          reset;
  logic [AW-1:0] gfxAddr;
  logic          gfxFlip;
  logic          gfxFlipEn;
  logic          gfxVal;
  logic          clearReq;
  logic          busy;
  logic          scanReq;
  logic          rowValid;
  logic          rowReady;
  logic [W-1:0]  rowData;
  logic [4:0]    rowIdx;
  logic          frameDone;

  chip8_framebuffer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .gfxAddr   (gfxAddr),
    .gfxFlip   (gfxFlip),
    .gfxFlipEn (gfxFlipEn),
    .gfxVal    (gfxVal),
    .clearReq  (clearReq),
    .busy      (busy),
    .scanReq   (scanReq),
    .rowValid  (rowValid),
    .rowReady  (rowReady),
    .rowData   (rowData),
    .rowIdx    (rowIdx),
    .frameDone (frameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Reference picture as a flat bitmap plus the set of changed rows.
  bit mdl_pix   [0:W*H-1];
  bit mdl_dirty [0:H-1];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mdl_row(input int y);
    logic [W-1:0] r;
    for (int x = 0; x < W; x++) r[x] = mdl_pix[pix_index(x, y)];
    return r;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < W*H; i++) mdl_pix[i] = 1'b0;
    for (int y = 0; y < H; y++) mdl_dirty[y] = 1'b1;
  endtask

  // One draw-port flip: collision bit before the edge, new value after.
  task automatic flip(input logic [AW-1:0] a);
    int idx;
    idx = int'(a) % (W*H);
    gfxAddr = a; gfxFlip = 1'b1; gfxFlipEn = 1'b1;
    #1;
    chk("gfxVal_pre", gfxVal, mdl_pix[idx]);
    cyc();
    mdl_pix[idx] = ~mdl_pix[idx];
    mdl_dirty[idx / W] = 1'b1;
    gfxFlipEn = 1'b0; gfxFlip = 1'b0;
    #1;
    chk("gfxVal_post", gfxVal, mdl_pix[idx]);
  endtask

  // Count busy cycles; optionally attempt a flip mid-clear, which must be dropped.
  task automatic wait_clear(input string tag, input bit drop_flip);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (drop_flip && n == 5) begin
        gfxAddr = 16'd3; gfxFlip = 1'b1; gfxFlipEn = 1'b1;
      end else begin
        gfxFlip = 1'b0; gfxFlipEn = 1'b0;
      end
      n++;
      cyc();
    end
    gfxFlip = 1'b0; gfxFlipEn = 1'b0;
    chk(tag, n, H);
    mdl_clear();
  endtask

  // One frame: rows expected from the model, optional stall, mid-frame clear
  // request, or a flip into the first offered row while it is held.
  task automatic scan_frame(input bit issue, input int stall_k, input int clear_k, input bit flip_first);
    int rows[$];
    int n;
    int ck;
    int fa;
    for (int y = 0; y < H; y++) begin
`ifdef CHIP8_FB_DIRTY_EN
      if (mdl_dirty[y]) rows.push_back(y);
`else
      rows.push_back(y);
`endif
    end
    ck = (clear_k >= rows.size()) ? rows.size() - 1 : clear_k;
    if (issue) begin
      scanReq = 1'b1;
      cyc();
      scanReq = 1'b0;
    end
    if (rows.size() == 0) begin
      #1;
      chk("empty_valid", rowValid, 1'b0);
      cyc();
    end
    foreach (rows[k]) begin
      n = 0;
      while (rowValid !== 1'b1 && n < 50) begin
        cyc();
        n++;
      end
      chk("row_valid", rowValid, 1'b1);
      chk("row_idx", rowIdx, rows[k]);
      chk("row_data", rowData, mdl_row(rows[k]));
      if (k == stall_k) begin
        rowReady = 1'b0;
        repeat (3) begin
          cyc();
          chk("stall_valid", rowValid, 1'b1);
          chk("stall_idx", rowIdx, rows[k]);
        end
      end
      if (flip_first && k == 0) begin
        rowReady = 1'b0;
        fa = rows[0] * W + int'($urandom_range(W - 1, 0));
        gfxAddr = AW'(fa); gfxFlip = 1'b1; gfxFlipEn = 1'b1;
        #1;
        chk("scanflip_pre", rowData, mdl_row(rows[0]));
        cyc();
        mdl_pix[fa] = ~mdl_pix[fa];
        gfxFlip = 1'b0; gfxFlipEn = 1'b0;
        #1;
        chk("scanflip_post", rowData, mdl_row(rows[0]));
        chk("scanflip_idx", rowIdx, rows[0]);
      end
      if (k == ck && clear_k >= 0) clearReq = 1'b1;
      rowReady = 1'b1;
      cyc();
      clearReq = 1'b0;
      rowReady = 1'b0;
      mdl_dirty[rows[k]] = 1'b0;
    end
    #1;
    chk("frame_done", frameDone, 1'b1);
    chk("done_valid", rowValid, 1'b0);
    if (clear_k >= 0) chk("busy_at_done", busy, 1'b0);
    cyc();
    chk("frame_done_pulse", frameDone, 1'b0);
    if (clear_k >= 0) begin
      chk("busy_after_done", busy, 1'b1);
      wait_clear("pending_clear_busy", 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; gfxAddr = '0; gfxFlip = 1'b0; gfxFlipEn = 1'b0;
    clearReq = 1'b0; scanReq = 1'b0; rowReady = 1'b0;
    cyc();
    chk("rst_busy", busy, 1'b1);
    chk("rst_valid", rowValid, 1'b0);
    chk("rst_done", frameDone, 1'b0);
    chk("rst_idx", rowIdx, 0);
    reset = 1'b0;
    wait_clear("reset_busy", 1'b0);

    scan_frame(1'b1, -1, -1, 1'b0);

    flip(16'h0045);
    flip(16'h0045);
    flip(16'h0805);
    scan_frame(1'b1, -1, -1, 1'b0);

`ifdef CHIP8_FB_DIRTY_EN
    scan_frame(1'b1, -1, -1, 1'b0);
    flip(AW'(pix_index(9, 3)));
    flip(AW'(pix_index(40, 17)));
    scan_frame(1'b1, -1, -1, 1'b0);
`endif

    repeat (40) flip(AW'($urandom_range(65535, 0)));
    scan_frame(1'b1, 2, 5, 1'b0);

    repeat (30) flip(AW'($urandom_range(65535, 0)));
    clearReq = 1'b1; scanReq = 1'b1;
    cyc();
    clearReq = 1'b0; scanReq = 1'b0;
    wait_clear("clr_scan_busy", 1'b1);
    scan_frame(1'b0, -1, -1, 1'b0);

    flip(16'd7);
    scan_frame(1'b1, -1, -1, 1'b1);

    repeat (10) flip(AW'($urandom_range(65535, 0)));
    scanReq = 1'b1;
    cyc();
    scanReq = 1'b0; rowReady = 1'b1;
    cyc();
    cyc();
    rowReady = 1'b0; reset = 1'b1;
    cyc();
    chk("midscan_rst_busy", busy, 1'b1);
    chk("midscan_rst_valid", rowValid, 1'b0);
    reset = 1'b0;
    wait_clear("midscan_rst_clear", 1'b0);
    scan_frame(1'b1, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
